// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helper for the round-robin push arbiter FIFO.
package fifo_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 10;

  // Bit width needed to hold values 0..v-1.
  // Never returns less than 1, so that degenerate sizes still get a real port.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: request vector -> one-hot grant plus encoded index.
// Priority rotates to the requester after the last granted one whenever
// 'advance' is high on a clock edge.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int n_req = N_REQ_DEF,
  localparam int IW    = clog2_min1(n_req)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [n_req-1:0] req,
  input  logic             advance,
  output logic [n_req-1:0] grant,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0] last_grant;
  // Clear after reset and set by the first grant. While it is clear, the scan
  // starts at requester 0. This gives requester 0 top priority after reset,
  // even though last_grant itself is reset to zero.
  logic          hist_vld;
  int            start;
  int            idx;
  logic          found;

  // First valid requester scanning upward from last_grant+1, modulo n_req.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    start     = hist_vld ? int'(last_grant) + 1 : 0;
    for (int i = 0; i < n_req; i++) begin
      idx = (start + i) % n_req;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Remember the winner only on cycles where its word was actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= '0;
      hist_vld   <= 1'b0;
    end else if (advance) begin
      last_grant <= grant_idx;
      hist_vld   <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// Flip-flop FIFO shared by n_req producers through a round-robin push arbiter.
// The FIFO has a single consumer, which uses pop, read_data and empty.
// Optional macro FIFO_ARB_SRC_ID_EN: each entry also stores the index of the
// requester that pushed it, and the head entry's index appears on read_src.
module fifo_rr_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int n_req = N_REQ_DEF,
  parameter  int width = WIDTH_DEF,
  parameter  int depth = DEPTH_DEF,
  localparam int IW    = clog2_min1(n_req),
  localparam int PW    = clog2_min1(depth),
  localparam int CW    = clog2_min1(depth + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  input  logic [n_req*width-1:0] req_data,
  output logic [n_req-1:0]       req_ready,
  input  logic                   pop,
  output logic [width-1:0]       read_data,
`ifdef FIFO_ARB_SRC_ID_EN
  output logic [IW-1:0]          read_src,
`endif
  output logic                   empty,
  output logic                   full,
  output logic [CW-1:0]          count
);

  logic [depth-1:0][width-1:0] mem;
`ifdef FIFO_ARB_SRC_ID_EN
  logic [depth-1:0][IW-1:0]    id_mem;
`endif
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_wrap, rd_wrap;
  logic [n_req-1:0] arb_req;
  logic [n_req-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             push, pop_eff;
  logic [width-1:0] push_data;

  // Requests are masked while the FIFO is full or in reset.
  // Because of this mask, req_ready never depends on pop.
  assign arb_req   = req_valid & {n_req{~full & ~rst}};
  assign req_ready = grant;
  assign push      = |grant;
  assign pop_eff   = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
  assign full  = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);

  rr_arbiter #(.n_req(n_req)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .advance   (push),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Select the granted requester's word.
  // When nothing is granted, the index is 0 and the word is never stored.
  always_comb push_data = req_data[int'(grant_idx)*width +: width];

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]    <= push_data;
`ifdef FIFO_ARB_SRC_ID_EN
      id_mem[wr_ptr] <= grant_idx;
`endif
    end
  end

  // Pointers wrap from depth-1 to 0 and toggle their wrap bit.
  // Count moves only when exactly one of push and effective pop happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_wrap <= 1'b0;
      rd_wrap <= 1'b0;
      count   <= '0;
    end else begin
      if (push) begin
        if (wr_ptr == PW'(depth - 1)) begin
          wr_ptr  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_ptr  <= wr_ptr + PW'(1);
        end
      end
      if (pop_eff) begin
        if (rd_ptr == PW'(depth - 1)) begin
          rd_ptr  <= '0;
          rd_wrap <= ~rd_wrap;
        end else begin
          rd_ptr  <= rd_ptr + PW'(1);
        end
      end
      case ({push, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The head entry is read combinationally, with no read latency.
  assign read_data = mem[rd_ptr];
`ifdef FIFO_ARB_SRC_ID_EN
  assign read_src  = id_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// Directed self-checking bench for fifo_rr_push_arbiter (n_req=4, width=8, depth=10).
module tb_fifo_rr_push_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 10;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           pop;
  logic [W-1:0]   read_data;
`ifdef FIFO_ARB_SRC_ID_EN
  logic [1:0]     read_src;
`endif
  logic           empty;
  logic           full;
  logic [3:0]     count;

  int checks   = 0;
  int failures = 0;

  fifo_rr_push_arbiter #(.n_req(N), .width(W), .depth(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pop       (pop),
    .read_data (read_data),
`ifdef FIFO_ARB_SRC_ID_EN
    .read_src  (read_src),
`endif
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    req_data  = '0;
    pop       = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    req_valid = 4'hF;
    rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    apply_reset();
  endtask

  // Requesters 0 and 2 alternate, and the data reads back in grant order.
  task automatic test_rr_two();
    int     exp_g[4];
    logic [W-1:0] exp_w[4];
    exp_g = '{0, 2, 0, 2};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(i*16 + k);
      exp_w[k] = 8'(exp_g[k]*16 + k);
      req_valid = 4'b0101;
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_g[k])) begin
        failures++; $display("FAIL rr2_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << exp_g[k]));
      end
      tick();
    end
    req_valid = '0;
    #1;
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL rr2_count got=%0d exp=4", count); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (read_data !== exp_w[k]) begin failures++; $display("FAIL rr2_data%0d got=%h exp=%h", k, read_data, exp_w[k]); end
`ifdef FIFO_ARB_SRC_ID_EN
      checks++;
      if (read_src !== 2'(exp_g[k])) begin failures++; $display("FAIL rr2_src%0d got=%0d exp=%0d", k, read_src, exp_g[k]); end
`endif
      pop = 1'b1;
      tick();
      pop = 1'b0;
      #1;
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rr2_empty got=%b exp=1", empty); end
  endtask

  // All requesters are valid until the FIFO fills. Then one pop is issued
  // while all requesters stay valid.
  task automatic test_fill_and_full_pop();
    apply_reset();
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'h40 + k);
      req_valid = 4'hF;
      #1;
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        failures++; $display("FAIL fill_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 4'd10) begin failures++; $display("FAIL fill_count got=%0d exp=10", count); end
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL full_ready got=%b exp=0000", req_ready); end
    checks++; if (count !== 4'd10) begin failures++; $display("FAIL full_hold_count got=%0d exp=10", count); end
    // Pop while full. The grant is still blocked during this cycle.
    pop = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL fullpop_ready got=%b exp=0000", req_ready); end
    checks++; if (read_data !== 8'h40) begin failures++; $display("FAIL fullpop_head got=%h exp=40", read_data); end
    tick();
    pop = 1'b0;
    #1;
    checks++; if (count !== 4'd9) begin failures++; $display("FAIL fullpop_count got=%0d exp=9", count); end
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL reopen_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (count !== 4'd10) begin failures++; $display("FAIL reopen_count got=%0d exp=10", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL reopen_full got=%b exp=1", full); end
  endtask

  // Pop on an empty FIFO combined with a push: only the push takes effect.
  task automatic test_empty_pop_push();
    apply_reset();
    req_data[1*W +: W] = 8'hA5;
    req_valid = 4'b0010;
    pop = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL epp_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    pop = 1'b0;
    #1;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL epp_count got=%0d exp=1", count); end
    checks++; if (read_data !== 8'hA5) begin failures++; $display("FAIL epp_data got=%h exp=a5", read_data); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL epp_empty got=%b exp=0", empty); end
`ifdef FIFO_ARB_SRC_ID_EN
    checks++; if (read_src !== 2'd1) begin failures++; $display("FAIL epp_src got=%0d exp=1", read_src); end
`endif
  endtask

  // Push 0..29 while occupancy is held at 5. The pointers wrap several times.
  task automatic test_wrap();
    int nxt_rd;
    nxt_rd = 0;
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      req_data[0 +: W] = 8'(k);
      req_valid = 4'b0001;
      pop = (k >= 5);
      #1;
      if (pop) begin
        checks++;
        if (read_data !== 8'(nxt_rd)) begin failures++; $display("FAIL wrap_data%0d got=%0d exp=%0d", nxt_rd, read_data, nxt_rd); end
        nxt_rd++;
      end
      tick();
      if (k == 5 || k == 17 || k == 29) begin
        checks++;
        if (count !== 4'd5) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=5", k, count); end
      end
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      pop = 1'b1;
      #1;
      checks++;
      if (read_data !== 8'(nxt_rd)) begin failures++; $display("FAIL wrap_tail%0d got=%0d exp=%0d", nxt_rd, read_data, nxt_rd); end
      nxt_rd++;
      tick();
    end
    pop = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  // Reset is pulsed in the middle of a cycle while the FIFO holds data.
  task automatic test_mid_reset();
    apply_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (count !== 4'd6) begin failures++; $display("FAIL mr_pre_count got=%0d exp=6", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mr_empty got=%b exp=1", empty); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL mr_count got=%0d exp=0", count); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mr_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mr_ready_hold got=%b exp=0000", req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mr_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL mr_post_count got=%0d exp=1", count); end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    pop       = 1'b0;
    test_reset();
    test_rr_two();
    test_fill_and_full_pop();
    test_empty_pop_push();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
